// File: rtl/tx_gearbox.sv
// TX 66b-to-32b gearbox: packs {payload, sync header} blocks into a
// continuous 32-bit PMA word stream, throttling upstream every 32 blocks.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_data[31:0]       scrambled payload word (bit 0 first)
//   i_data_valid       payload word present
//   i_hdr[1:0]         sync header, used on the first word of a block
//   i_hdr_valid        marks the first word of a block
//   o_ready            registered; upstream may present a word while high
//   o_data[31:0]       gearboxed word to PMA (bit 0 first)
//   o_data_valid       o_data carries valid line bits
//   o_align_err        pulse: i_hdr_valid disagreed with word phase
//   o_underflow        pulse: no word offered while ready after start
`timescale 1ns/1ps

module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_hdr_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_align_err,
  output logic                  o_underflow
);

  if (DATA_WIDTH != 32 || HDR_WIDTH != 2) begin : g_bad_param
    $error("tx_gearbox supports only DATA_WIDTH=32, HDR_WIDTH=2");
  end

  // Worst case: 62 leftover bits plus a 34-bit header word.
  localparam int BUF_W  = 3 * DATA_WIDTH + HDR_WIDTH;
  localparam int FILL_W = 7;
  localparam int SEQ_W  = 6;

  localparam logic [FILL_W-1:0] N_DAT = FILL_W'(DATA_WIDTH);
  localparam logic [FILL_W-1:0] N_HDR = FILL_W'(DATA_WIDTH + HDR_WIDTH);
  localparam logic [SEQ_W-1:0]  SEQ_MAX = SEQ_W'(32);

  logic [BUF_W-1:0]      sbuf_q, sbuf_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  phase_q, phase_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic                  pause_q, pause_d;
  logic                  started_q, started_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  align_q, align_d;
  logic                  uflow_q, uflow_d;

  logic                  accept;
  logic [BUF_W-1:0]      app;
  logic [BUF_W-1:0]      merged;
  logic [FILL_W-1:0]     add;
  logic [FILL_W-1:0]     fill_app;

  always_comb begin
    accept    = i_data_valid && ready_q;
    app       = '0;
    add       = '0;
    if (accept) begin
      if (!phase_q) begin
        app[DATA_WIDTH+HDR_WIDTH-1:0] = {i_data, i_hdr};
        add = N_HDR;
      end else begin
        app[DATA_WIDTH-1:0] = i_data;
        add = N_DAT;
      end
    end
    // Bits above fill are always zero, so OR-in is an append.
    merged   = sbuf_q | (app << fill_q);
    fill_app = fill_q + add;

    sbuf_d  = merged;
    fill_d  = fill_app;
    data_d  = data_q;
    valid_d = 1'b0;
    if (fill_app >= N_DAT) begin
      data_d  = merged[DATA_WIDTH-1:0];
      valid_d = 1'b1;
      sbuf_d  = merged >> DATA_WIDTH;
      fill_d  = fill_app - N_DAT;
    end

    phase_d   = phase_q ^ accept;
    seq_d     = seq_q;
    pause_d   = pause_q;
    if (accept && phase_q) begin
      seq_d = seq_q + 1'b1;
    end
    // Two idle input cycles let the buffer drain its 64 surplus bits.
    if (seq_q == SEQ_MAX) begin
      if (pause_q) begin
        seq_d   = '0;
        pause_d = 1'b0;
      end else begin
        pause_d = 1'b1;
      end
    end

    started_d = started_q | accept;
    ready_d   = (seq_d != SEQ_MAX);
    align_d   = accept && (i_hdr_valid != !phase_q);
    uflow_d   = started_q && ready_q && !i_data_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sbuf_q    <= '0;
      fill_q    <= '0;
      phase_q   <= 1'b0;
      seq_q     <= '0;
      pause_q   <= 1'b0;
      started_q <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      align_q   <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      sbuf_q    <= sbuf_d;
      fill_q    <= fill_d;
      phase_q   <= phase_d;
      seq_q     <= seq_d;
      pause_q   <= pause_d;
      started_q <= started_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      align_q   <= align_d;
      uflow_q   <= uflow_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_align_err  = align_q;
  assign o_underflow  = uflow_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// Self-checking bench for tx_gearbox: bit-level scoreboard of the
// serialised line stream plus directed pause/align/underflow/reset steps.
`timescale 1ns/1ps

module tb_tx_gearbox;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic [1:0]  i_hdr;
  logic        i_hdr_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_align_err;
  logic        o_underflow;

  tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_hdr        (i_hdr),
    .i_hdr_valid  (i_hdr_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_align_err  (o_align_err),
    .o_underflow  (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // scoreboard: line bits in transmit order
  logic        bq[$];
  logic        mphase;
  logic        mstarted;
  int          mblocks;
  logic [31:0] last_exp;
  int          lowrun;
  int          pauses;
  int          gaps;
  int          align_cnt;
  int          uf_cnt;
  int          salt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic dv, input logic hv,
                      input logic [1:0] hdr, input logic [31:0] d);
    logic acc, ea, eu, ev;
    logic [31:0] w;
    i_data_valid = dv;
    i_hdr_valid  = hv;
    i_hdr        = hdr;
    i_data       = d;
    acc = dv && o_ready;
    ea  = acc && (hv != !mphase);
    eu  = mstarted && o_ready && !dv;
    if (acc) begin
      if (!mphase) begin
        for (int i = 0; i < 2; i++) bq.push_back(hdr[i]);
      end
      for (int i = 0; i < 32; i++) bq.push_back(d[i]);
      if (mphase) mblocks++;
      mphase   = !mphase;
      mstarted = 1'b1;
    end
    @(posedge i_clk);
    #1;
    ev = (bq.size() >= 32);
    chk("valid", {31'b0, o_data_valid}, {31'b0, ev});
    if (ev) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
      chk("data", o_data, w);
      last_exp = w;
    end else begin
      chk("hold", o_data, last_exp);
    end
    chk("align", {31'b0, o_align_err}, {31'b0, ea});
    chk("uflow", {31'b0, o_underflow}, {31'b0, eu});
    if (o_align_err) align_cnt++;
    if (o_underflow) uf_cnt++;
    if (mstarted && !o_data_valid) gaps++;
    if (!o_ready) begin
      lowrun++;
    end else if (lowrun > 0) begin
      chk("pause_len", 32'(lowrun), 32'd2);
      chk("pause_at", 32'(mblocks % 32), 32'd0);
      pauses++;
      lowrun = 0;
    end
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    i_data_valid = 1'b0;
    i_hdr_valid  = 1'b0;
    i_hdr        = 2'b00;
    i_data       = '0;
    @(posedge i_clk);
    #1;
    chk("rst_data", o_data, 32'h0);
    chk("rst_valid", {31'b0, o_data_valid}, 32'h0);
    chk("rst_ready", {31'b0, o_ready}, 32'h0);
    chk("rst_align", {31'b0, o_align_err}, 32'h0);
    chk("rst_uflow", {31'b0, o_underflow}, 32'h0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rel_ready", {31'b0, o_ready}, 32'h1);
    chk("rel_valid", {31'b0, o_data_valid}, 32'h0);
    bq.delete();
    mphase    = 1'b0;
    mstarted  = 1'b0;
    mblocks   = 0;
    last_exp  = '0;
    lowrun    = 0;
    pauses    = 0;
    gaps      = 0;
    align_cnt = 0;
    uf_cnt    = 0;
  endtask

  task automatic stream(input int nblk, input bit fixed,
                        input int align_k, input int gap_k);
    int k, cyc;
    bit gapped;
    logic [31:0] d;
    logic [1:0] h;
    logic hv, dv, acc;
    k = 0;
    cyc = 0;
    gapped = 0;
    salt++;
    while (k < 2 * nblk && cyc < 4 * nblk + 20) begin
      if (fixed) begin
        h = 2'b01;
        d = (k % 2 == 1) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      end else begin
        h = ((k / 2) % 2 == 1) ? 2'b10 : 2'b01;
        d = 32'(k + 1) * 32'h9E3779B1 + 32'(salt) * 32'h0F1E2D3C;
      end
      hv = (k % 2 == 0) || (k == align_k);
      dv = 1'b1;
      if (k == gap_k && !gapped && o_ready) begin
        dv = 1'b0;
        gapped = 1;
      end
      acc = dv && o_ready;
      step(dv, hv, h, d);
      if (acc) k++;
      cyc++;
    end
    chk("stream_done", 32'(k), 32'(2 * nblk));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = 0;
    do_reset();

    // first output word carries header bits then payload
    step(1'b1, 1'b1, 2'b01, 32'hA5A5A5A5);
    chk("first_word", o_data, 32'h96969695);
    chk("first_valid", {31'b0, o_data_valid}, 32'h1);
    step(1'b1, 1'b0, 2'b01, 32'h5A5A5A5A);
    stream(4, 1'b1, -1, -1);
    chk("fixed_gaps", 32'(gaps), 32'd0);

    // 33 blocks: one pause after block 32, continuous output
    do_reset();
    stream(33, 1'b0, -1, -1);
    chk("pauses_33", 32'(pauses), 32'd1);
    chk("gaps_33", 32'(gaps), 32'd0);
    chk("noalign_33", 32'(align_cnt), 32'd0);
    chk("nouflow_33", 32'(uf_cnt), 32'd0);

    // header-valid flag on a second word
    stream(8, 1'b0, 3, -1);
    chk("align_cnt", 32'(align_cnt), 32'd1);
    chk("gaps_align", 32'(gaps), 32'd0);

    // one idle cycle while ready; next pause must stay at block 64
    stream(30, 1'b0, -1, 6);
    chk("uf_cnt", 32'(uf_cnt), 32'd1);
    chk("pauses_uf", 32'(pauses), 32'd2);
    chk("gaps_uf", 32'(gaps), 32'd1);

    // reset after the header word of a block
    step(1'b1, 1'b1, 2'b10, 32'h13579BDF);
    do_reset();
    step(1'b1, 1'b1, 2'b01, 32'hA5A5A5A5);
    chk("restart_word", o_data, 32'h96969695);
    step(1'b1, 1'b0, 2'b01, 32'h5A5A5A5A);
    stream(2, 1'b1, -1, -1);
    chk("restart_gaps", 32'(gaps), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_gearbox.md
Name: tx_gearbox

Overview:
- TX 66b-to-32b gearbox. Sits directly downstream of the 64b/66b scrambler and feeds the 32-bit SERDES/PMA interface.
- Accepts each 66-bit block as two 32-bit scrambled payload words, with a 2-bit sync header on the first word. The header arrives from the encoder, delay-matched around the scrambler.
- Packs these into a continuous 32-bit output stream. Throttles upstream with a 2-cycle pause every 32 blocks, because 32 blocks × 66 bits = 66 words × 32 bits.

Parameters:
- DATA_WIDTH, 32, payload and output word width. Only 32 is supported; any other value is an elaboration error.
- HDR_WIDTH, 2, sync header width. Fixed at 2.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_data  input  32  scrambled payload word, bit 0 transmitted first.
- i_data_valid  input  1  payload word present.
- i_hdr  input  2  sync header (2'b01 data, 2'b10 control); sampled only on the first word of a block.
- i_hdr_valid  input  1  marks the first word of a block.
- o_ready  output  1  registered; upstream may present a word only while high.
- o_data  output  32  gearboxed word to PMA, bit 0 first.
- o_data_valid  output  1  o_data carries valid line bits.
- o_align_err  output  1  one-cycle pulse: i_hdr_valid disagrees with expected word phase.
- o_underflow  output  1  one-cycle pulse: o_ready high but i_data_valid low after streaming started.

Behaviour:
- Clock and reset:
  - One clock (i_clk).
  - Reset is synchronous, active-high (i_reset).
  - While i_reset is high, all state clears: buffer empty (fill=0), phase=0, seq=0, pause_cnt=0, started=0, o_ready=0, o_data=0, o_data_valid=0, o_align_err=0, o_underflow=0.
  - Reset asserted mid-block discards partial data; no output flush.
- Accept rule: a word is accepted when i_data_valid && o_ready. Words presented while o_ready=0 are ignored.
- Phase:
  - phase=0 expects a header word; phase=1 expects the second word.
  - Each accept toggles phase.
  - On an accept with phase=0, the bits appended are {i_data, i_hdr}: hdr bit 0 first, then data bit 0. This adds 34 bits.
  - On an accept with phase=1, only i_data is appended. This adds 32 bits.
  - The accept at phase=1 ends a block: seq increments.
- Alignment error:
  - If i_hdr_valid != (phase==0) on an accept, pulse o_align_err the next cycle.
  - The word is still consumed according to the internal phase. The phase is not resynchronised.
- Bit buffer:
  - Shift buffer of at least 98 bits, with fill count 0..98.
  - Incoming bits are placed at bit position fill.
  - Each cycle with fill_after_append >= 32:
    - o_data <= buffer[31:0]
    - o_data_valid <= 1
    - buffer shifts right by 32
    - fill decreases by 32
  - Otherwise o_data_valid <= 0 and o_data holds its value.
  - Latency: 1 cycle from accept to first output containing those bits.
- Sequence and pause:
  - seq counts blocks 0..32.
  - o_ready is registered as (seq != 32), and is 0 in the first cycle after reset deassertion.
  - When seq==32, pause_cnt counts 2 cycles (o_ready low exactly 2 cycles), then seq <= 0.
  - Fill is 64 at pause entry and 0 at pause exit; output stays continuous through the pause.
- Steady state: once started, o_data_valid=1 every cycle, provided upstream supplies every ready cycle. The 66-cycle period is 64 accepts plus 2 pause cycles.
- Underflow:
  - started is set on the first accepted word.
  - If started && o_ready && !i_data_valid, pulse o_underflow the next cycle.
  - seq and phase hold, and the buffer drains; o_data_valid drops when fill < 32.
- Start-up: the first word can be presented in the cycle after o_ready first rises. Same-cycle accept and output consume are both handled in one update.

Test Plan:
- Reset release, then a continuous stream of blocks (hdr=2'b01, data words 0xA5A5A5A5 and 0x5A5A5A5A):
  - first o_data = {0xA5A5A5A5[29:0], 2'b01}, one cycle after the first accept;
  - o_data_valid then stays 1 continuously.
- 33 blocks streamed continuously:
  - o_ready drops for exactly 2 cycles after the 32nd block's second word, then returns to 1;
  - concatenated output of 66 words equals the 32 input blocks in order, header-first;
  - no gaps in o_data_valid.
- Assert i_hdr_valid on a second word:
  - o_align_err pulses once, the cycle after;
  - the output bitstream still treats the word as payload (no header inserted).
- Drop i_data_valid for 1 cycle mid-stream while o_ready=1:
  - o_underflow pulses once;
  - seq does not advance;
  - o_data_valid drops in the cycle where fill falls below 32.
- Assert i_reset for 1 cycle mid-block (phase=1, fill=34):
  - next cycle: o_data_valid=0, o_data=0, o_ready=0;
  - the following cycle o_ready=1, and the stream restarts with seq=0, phase=0.
